// File: rtl/rcs64_seq.sv
// rcs64_seq: sequential 64-bit ripple-borrow subtractor, d = a - b - bin.
// Resolves one 16-bit slice per clock with the borrow registered between
// slices. Operands and results move over valid/ready handshakes.
// Build option: define RCS64_SAT_EN to saturate d on signed overflow.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | subtracting slice k (0..3), one slice per cycle
// DONE  | result held on d/bout/ovf, out_valid=1

module rcs64_seq #(
  parameter int W_SLICE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] d,
  output logic        bout,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [63:0]        a_r, b_r;
  logic               brw;
  logic [1:0]         k;
  logic [63:0]        d_r;
  logic               bout_r, ovf_r;
  logic [5:0]         lsb;
  logic [W_SLICE-1:0] a_k, b_k;
  logic [W_SLICE:0]   diff;
  logic               ovf_raw;

  // Slice operand select and 17-bit subtract; bit 16 of diff is the new borrow.
  // The slice base assumes 16-bit slices, the only supported width.
  always_comb begin
    lsb     = {k, 4'b0000};
    a_k     = a_r[lsb +: W_SLICE];
    b_k     = b_r[lsb +: W_SLICE];
    diff    = {1'b0, a_k} - {1'b0, b_k} - {{W_SLICE{1'b0}}, brw};
    ovf_raw = (a_r[63] != b_r[63]) && (diff[W_SLICE-1] != a_r[63]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; handshake outputs depend on state (and rst) only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (k == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice result/borrow registers and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      brw    <= 1'b0;
      k      <= 2'd0;
      d_r    <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            brw <= bin;
            k   <= 2'd0;
          end
        end
        CALC: begin
          brw                  <= diff[W_SLICE];
          k                    <= k + 2'd1;
          d_r[lsb +: W_SLICE]  <= diff[W_SLICE-1:0];
          if (k == 2'd3) begin
            bout_r <= diff[W_SLICE];
            ovf_r  <= ovf_raw;
`ifdef RCS64_SAT_EN
            // Saturation replaces the whole word on the last slice edge,
            // so it adds no latency; flags keep reporting the raw result.
            if (ovf_raw)
              d_r <= a_r[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = d_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule
